// File: rtl/cic_pkg.sv
// Shared constants and elaboration helpers for the CIC integrator/decimator.
package cic_pkg;

   localparam int N_MIN = 1;
   localparam int N_MAX = 8;
   localparam int R_MIN = 1;
   localparam int R_MAX = 64;

   function automatic int cic_w(input int win, input int wg);
      return win + wg;
   endfunction

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // R=1 still needs a one-bit counter register
   function automatic int cnt_w(input int r);
      return (clog2(r) < 1) ? 1 : clog2(r);
   endfunction

endpackage

// File: rtl/cic_int_decim_if.sv
// Sample stream bundle: clear, input sample and decimated output strobe.
interface cic_int_decim_if #(
   parameter int Win = 16,
   parameter int W   = 38
);
   logic                  clr;
   logic                  val_in;
   logic signed [Win-1:0] data_in;
   logic                  val_out;
   logic signed [W-1:0]   data_out;

   modport master (
      output clr, val_in, data_in,
      input  val_out, data_out
   );

   modport slave (
      input  clr, val_in, data_in,
      output val_out, data_out
   );
endinterface

// File: rtl/cic_int_stage.sv
// One CIC integrator: wrapping W-bit accumulator with enable and clear.
module cic_int_stage
   import cic_pkg::*;
#(
   parameter int W = cic_w(16, 22)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr_i,
   input  logic                en_i,
   input  logic signed [W-1:0] src_i,
   output logic signed [W-1:0] acc_o
);

   logic signed [W-1:0] acc_q, acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clr_i)
         acc_d = '0;
      else if (en_i)
         acc_d = acc_q + src_i;
   end

   always_ff @(posedge clk) begin
      if (rst)
         acc_q <= '0;
      else
         acc_q <= acc_d;
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/cic_int_decim.sv
// N-stage CIC integrator chain followed by a 1-in-R decimator.
module cic_int_decim
   import cic_pkg::*;
#(
   parameter int Win = 16,
   parameter int Wg  = 22,
   parameter int N   = 3,
   parameter int R   = 4
) (
   input  logic           clk,
   input  logic           rst,
   cic_int_decim_if.slave bus
);

   localparam int W  = cic_w(Win, Wg);
   localparam int CW = cnt_w(R);
   localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

   if (N < N_MIN || N > N_MAX || R < R_MIN || R > R_MAX) begin : g_bad_param
      $error("cic_int_decim: N or R out of legal range");
   end

   logic [N:1]          v_q, v_d;
   logic [N:0]          v;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic signed [W-1:0] dout_q, dout_d;
   logic                vout_q, vout_d;
   logic signed [W-1:0] src [1:N];
   logic signed [W-1:0] acc [1:N];

   assign v = {v_q, bus.val_in};

   // each stage advances only when its input sample's valid arrives
   for (genvar k = 1; k <= N; k++) begin : g_stage
      if (k == 1) begin : g_first
         assign src[k] = W'(bus.data_in);
      end else begin : g_next
         assign src[k] = acc[k-1];
      end

      cic_int_stage #(.W(W)) u_stage (
         .clk   (clk),
         .rst   (rst),
         .clr_i (bus.clr),
         .en_i  (v[k-1]),
         .src_i (src[k]),
         .acc_o (acc[k])
      );
   end

   always_comb begin
      v_d    = v[N-1:0];
      cnt_d  = cnt_q;
      dout_d = dout_q;
      vout_d = 1'b0;
      if (v[N]) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            vout_d = 1'b1;
            dout_d = acc[N];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      if (bus.clr) begin
         v_d    = '0;
         cnt_d  = '0;
         dout_d = dout_q;
         vout_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q    <= '0;
         cnt_q  <= '0;
         dout_q <= '0;
         vout_q <= 1'b0;
      end else begin
         v_q    <= v_d;
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
         vout_q <= vout_d;
      end
   end

   assign bus.val_out  = vout_q;
   assign bus.data_out = dout_q;

endmodule

// File: doc/cic_int_decim.md
CIC_INT_DECIM -- requirements
Module: cic_int_decim

Interface
REQ-001 Parameter Win, default 16, input sample width (signed).
REQ-002 Parameter Wg, default 22, growth bits; internal/output width W = Wg+Win.
REQ-003 Parameter N, default 3, number of cascaded integrator stages, legal 1..8.
REQ-004 Parameter R, default 4, decimation ratio, legal 1..64.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 clr  input  1  synchronous accumulator/counter clear, active-high.
REQ-008 val_in  input  1  data_in valid qualifier.
REQ-009 data_in  input  Win  signed input sample.
REQ-010 val_out  output  1  one-cycle strobe, data_out valid.
REQ-011 data_out  output  W  signed decimated integrator output.

Function
REQ-012 data_in SHALL be sign-extended to W bits before stage 1.
REQ-013 Valid pipeline v[0..N], v[0]=val_in; v[k] SHALL register v[k-1] every cycle.
REQ-014 Stage k SHALL update acc[k] <= acc[k] + src[k] only when v[k-1]=1; src[1]=extended data_in, src[k]=acc[k-1] for k>1; otherwise acc[k] holds.
REQ-015 All additions SHALL be W-bit two's complement, wrapping modulo 2^W, no saturation, no overflow flag.
REQ-016 Decimation counter cnt (0..R-1) SHALL increment on each cycle with v[N]=1, wrapping to 0 after R-1.
REQ-017 When v[N]=1 and cnt=R-1: next cycle data_out SHALL equal acc[N] and val_out SHALL be 1 for exactly one cycle.
REQ-018 Latency: val_in to val_out = N+1 cycles for the sample completing a decimation group.
REQ-019 val_out SHALL be 0 in all other cycles; data_out SHALL hold its last value between strobes.
REQ-020 R=1 SHALL emit one output per input sample.
REQ-021 val_in gaps SHALL freeze all stage and counter state; output sequence SHALL be identical to gap-free input.
REQ-022 clr=1 SHALL zero all acc[k], v[1..N] and cnt next cycle and force val_out=0; data_out holds; clr has priority over val_in.
REQ-023 Samples in flight when clr or rst asserted SHALL be discarded.
REQ-024 val_in accepted every cycle; no backpressure.

Reset
REQ-025 rst=1 SHALL zero acc[1..N], v[1..N], cnt, data_out and val_out at the next edge.
REQ-026 rst SHALL take priority over clr and val_in.
REQ-027 First val_in after rst deasserts SHALL be processed normally.

Structure
REQ-028 Package cic_pkg SHALL hold W computation, N/R legal limits and counter-width function clog2(R).
REQ-029 One sub-module cic_int_stage (single accumulator, enable, clear, W-bit wrap add) SHALL be instantiated N times by generate.
REQ-030 Elaboration SHALL fail for N or R outside legal range.

Verification
REQ-031 N=3,R=1: impulse 1 then zeros, val_in continuous -> data_out 1,3,6,10,15..., first val_out 4 cycles after impulse.
REQ-032 N=1,R=4: data_in=1 continuous -> val_out every 4th cycle, data_out 4,8,12,16.
REQ-033 N=1,R=1,Win=4,Wg=0: data_in=7 repeated -> data_out 7,-2,5,-4 (wrap).
REQ-034 N=2,R=2: random val_in gaps vs contiguous run of same samples -> identical data_out sequence.
REQ-035 clr pulse mid-stream (N=1,R=4, data_in=1) -> no val_out for 4 valid samples after clr, then data_out=4.
REQ-036 rst asserted with val_in=1 mid-group -> next cycle val_out=0, data_out=0; after release, sequence restarts as from power-up.
